gray_ptr_sync: RTL and testbench

- Parametrised destination-side synchronizer for gray-coded pointers or counters that arrive from another clock domain.
- Adds over the previous generation:
  - configurable number of flop stages;
  - asynchronous reset to a programmable value;
  - a registered binary output;
  - an update pulse and a modulo delta output;
  - a sticky error flag that detects illegal multi-bit gray transitions.
- Sits in the receiving domain of the async FIFO: it consumes the remote pointer and feeds the full/empty logic.

---
 rtl/gray_ptr_sync.sv | 68 ++++++
 tb/tb_gray_ptr_sync.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/gray_ptr_sync.sv
// gray_ptr_sync: destination-domain synchronizer for gray-coded pointers, with a
// registered binary view, update pulse, modulo delta and an illegal-step checker.
module gray_ptr_sync #(
    parameter int WIDTH    = 4,
    parameter int STAGES   = 2,
    parameter int RST_VAL  = 0,
    parameter bit CHECK_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] gray_o,
    output logic [WIDTH-1:0] bin_o,
    output logic [WIDTH-1:0] delta_o,
    output logic             update_o,
    output logic             err_o,
    input  logic             err_clr_i
);
    localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RST_VAL);
    localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);

    if (STAGES < 2 || STAGES > 4 || WIDTH < 2 || WIDTH > 16) begin : g_bad_param
        $error("gray_ptr_sync: STAGES must be 2..4 and WIDTH 2..16");
    end

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b = g;
        for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync [STAGES];
    logic [WIDTH-1:0] prev_gray, bin_next, diff;
    logic             multi;

    assign gray_o   = sync[STAGES-1];
    assign bin_next = gray2bin(gray_o);
    assign diff     = gray_o ^ prev_gray;
    // more than one set bit in diff means an illegal gray step
    assign multi    = CHECK_EN && ((diff & (diff - WIDTH'(1))) != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) sync[k] <= RST_GRAY;
        end else begin
            sync[0] <= gray_i;
            for (int k = 1; k < STAGES; k++) sync[k] <= sync[k-1];
        end
    end

    // bin_o always equals gray2bin(prev_gray), so it serves as the previous binary value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_gray <= RST_GRAY;
            bin_o     <= RST_BIN;
            delta_o   <= '0;
            update_o  <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            prev_gray <= gray_o;
            bin_o     <= bin_next;
            delta_o   <= (diff != '0) ? bin_next - bin_o : delta_o;
            update_o  <= diff != '0;
            err_o     <= multi || (err_o && !err_clr_i);
        end
    end
endmodule

// File: tb/tb_gray_ptr_sync.sv
// tb_gray_ptr_sync: directed bench over five instances sharing one stimulus
// (0: RST_VAL=5, 1: base, 2: STAGES=3, 3: STAGES=4, 4: CHECK_EN=0).
module tb_gray_ptr_sync;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] gray_i = 4'b0111;
    logic       err_clr_i = 1'b0;
    logic [3:0] gray [5];
    logic [3:0] bin [5];
    logic [3:0] delta [5];
    logic       upd [5];
    logic       err [5];
    int         n_checks = 0;
    int         n_fail = 0;
    int         n_upd;

    always #5 clk = ~clk;

    for (genvar i = 0; i < 5; i++) begin : g_dut
        gray_ptr_sync #(
            .WIDTH(4),
            .STAGES(i == 2 ? 3 : i == 3 ? 4 : 2),
            .RST_VAL(i == 0 ? 5 : 0),
            .CHECK_EN(i != 4)
        ) dut (
            .clk(clk),
            .rst_n(rst_n),
            .gray_i(gray_i),
            .gray_o(gray[i]),
            .bin_o(bin[i]),
            .delta_o(delta[i]),
            .update_o(upd[i]),
            .err_o(err[i]),
            .err_clr_i(err_clr_i)
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] g);
        rst_n = 1'b0;
        gray_i = g;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    initial begin
        // reset with RST_VAL=5 (gray 0111)
        repeat (2) tick();
        check("rst_bin", bin[0], 5);
        check("rst_gray", gray[0], 4'b0111);
        check("rst_upd", upd[0], 0);
        check("rst_err", err[0], 0);
        check("rst_delta", delta[0], 0);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rel_bin", bin[0], 5);
            check("rel_gray", gray[0], 4'b0111);
            check("rel_upd", upd[0], 0);
            check("rel_err", err[0], 0);
        end

        // latency: gray 0000 -> 0001 ahead of edge e=0
        do_reset(4'b0000);
        gray_i = 4'b0001;
        for (int e = 0; e < 6; e++) begin
            tick();
            check("lat2_gray", gray[1], e >= 1);
            check("lat2_bin", bin[1], e >= 2);
            check("lat2_upd", upd[1], e == 2);
            check("lat3_gray", gray[2], e >= 2);
            check("lat3_upd", upd[2], e == 3);
            check("lat4_gray", gray[3], e >= 3);
            check("lat4_upd", upd[3], e == 4);
            check("lat4_bin", bin[3], e >= 4);
            if (e == 2) check("lat2_delta", delta[1], 1);
        end

        // wrap walk: park at bin 12 (gray 1010), clear the startup error, then walk 13,14,15,0,1
        gray_i = 4'b1010;
        repeat (4) tick();
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        check("pre_wrap_err", err[1], 0);
        n_upd = 0;
        foreach (gray[v]) begin end
        for (int s = 0; s < 5; s++) begin
            gray_i = (s == 0) ? 4'b1011 : (s == 1) ? 4'b1001 : (s == 2) ? 4'b1000 :
                     (s == 3) ? 4'b0000 : 4'b0001;
            for (int c = 0; c < 4; c++) begin
                tick();
                if (upd[1]) begin
                    n_upd++;
                    check("wrap_delta", delta[1], 1);
                end
                check("wrap_err", err[1], 0);
            end
        end
        check("wrap_pulses", n_upd, 5);
        // bin 1 -> 14 (gray 1001) -> 1 (gray 0001): delta 13 then 3
        gray_i = 4'b1001;
        repeat (4) tick();
        check("jump14_delta", delta[1], 13);
        gray_i = 4'b0001;
        repeat (4) tick();
        check("jump1_bin", bin[1], 1);
        check("jump1_delta", delta[1], 3);
        check("jump1_err", err[1], 0);

        // illegal step 0000 -> 0011 (bin 2)
        do_reset(4'b0000);
        gray_i = 4'b0011;
        for (int e = 0; e < 3; e++) begin
            tick();
            check("ill_bin", bin[1], e == 2 ? 2 : 0);
            check("ill_err", err[1], e == 2);
            check("ill_nochk_bin", bin[4], e == 2 ? 2 : 0);
            check("ill_nochk_err", err[4], 0);
        end
        check("ill_nochk_delta", delta[4], 2);
        for (int c = 0; c < 10; c++) begin
            tick();
            check("ill_hold", err[1], 1);
        end
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        check("ill_clear", err[1], 0);
        // clear coinciding with a new violation 0011 -> 0000
        gray_i = 4'b0000;
        repeat (2) tick();
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        check("set_wins", err[1], 1);
        check("set_wins_nochk", err[4], 0);
        check("nochk_bin0", bin[4], 0);
        check("nochk_delta14", delta[4], 14);
        tick();
        check("set_wins_hold", err[1], 1);

        // asynchronous reset mid-operation while update_o is high
        do_reset(4'b0000);
        gray_i = 4'b0001;
        repeat (3) tick();
        check("mid_pre_upd", upd[1], 1);
        check("mid_pre_delta", delta[1], 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_upd", upd[1], 0);
        check("mid_bin", bin[1], 0);
        check("mid_delta", delta[1], 0);
        check("mid_gray", gray[1], 0);
        check("mid_err", err[1], 0);
        check("mid_a_bin", bin[0], 5);
        check("mid_a_gray", gray[0], 4'b0111);
        rst_n = 1'b1;
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
